uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Transmit-side byte FIFO sitting directly upstream of the UART transmitter in CoreUARTapb. The APB register interface writes bytes in; the transmitter pops them with its active-low read strobe and takes the registered read data. Provides the empty and full flags the transmitter and the TXRDY status logic consume.

Parameters:
WIDTH, 8, data width in bits.
DEPTH_LOG2, 4, log2 of FIFO depth; depth = 2**DEPTH_LOG2 entries (16 by default).
AFULL_THRESH, 12, almost-full threshold in entries; used only with the optional feature.

Ports:
clk  input  1  system clock; all logic runs on it.
aresetn  input  1  asynchronous, active-low reset.
clear  input  1  synchronous flush, active-high.
wr_en  input  1  write strobe from the APB TX data register write, active-high.
wr_data  input  WIDTH  byte to enqueue.
rd_n  input  1  active-low read strobe from the transmitter.
rd_data  output  WIDTH  registered head-of-queue byte.
empty  output  1  FIFO holds 0 entries.
full  output  1  FIFO holds 2**DEPTH_LOG2 entries.
level  output  DEPTH_LOG2+1  current entry count.
overflow  output  1  sticky flag: a write was dropped.
almost_full  output  1  level >= AFULL_THRESH. Present only with UART_TX_FIFO_AFULL_EN.

Behaviour:
- Reset (aresetn low): wr_ptr = rd_ptr = 0, level = 0, empty = 1, full = 0, overflow = 0, rd_data = 0, almost_full = 0. Reset mid-operation discards all stored data immediately.
- Storage: 2**DEPTH_LOG2 x WIDTH array. Pointers are DEPTH_LOG2 bits wide and wrap naturally from depth-1 to 0. level is an explicit up/down counter of width DEPTH_LOG2+1.
- Write accepted when wr_en = 1 and (full = 0 or a read is accepted in the same cycle). On acceptance: mem[wr_ptr] <= wr_data, wr_ptr + 1.
- Read accepted when rd_n = 0 and empty = 0. On acceptance: rd_data <= mem[rd_ptr] on the same edge, rd_ptr + 1.
- Read latency: rd_data is valid one clk after the cycle in which rd_n is sampled low. It holds its value until the next accepted read. The transmitter samples rd_data at least two cycles after its strobe.
- Flags: empty, full and level are registered and update on the same edge as the pointer change. full = (level == depth); empty = (level == 0).
- Simultaneous read and write:
  - Not empty and not full: both are accepted and level is unchanged.
  - Full: both are accepted; no overflow is raised.
  - Empty: only the write is accepted. There is no fall-through, the read is ignored, and rd_data is unchanged.
- Read when empty: ignored. Pointers, level and rd_data are unchanged. There is no underflow flag.
- Write when full with no read: data is dropped, overflow <= 1. overflow stays set until clear or reset.
- clear = 1: on the next edge, pointers = 0, level = 0, empty = 1, full = 0, overflow = 0. rd_data holds its value. clear takes priority over any read or write in the same cycle.
- rd_n held low for multiple cycles pops one entry per cycle while the FIFO is not empty.

Optional Feature:
UART_TX_FIFO_AFULL_EN
- Defined: the almost_full port exists. It is registered and equals (next level >= AFULL_THRESH), updated on the same edge as level. It is cleared by reset and by clear.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then write 0xA5 (1 cycle), then rd_n low for 1 cycle -> empty 1->0->1, level 0->1->0, rd_data = 0xA5 one cycle after the strobe.
- Write 16 bytes 0x00..0x0F -> full = 1 and level = 16 after the 16th write. A 17th write of 0xFF -> overflow = 1 and level stays 16. Draining 16 reads returns 0x00..0x0F in order, with no 0xFF.
- With full = 1, pulse wr_en = 1 and rd_n = 0 together -> level stays 16, overflow stays 0, and the new byte appears as the 16th read.
- On an empty FIFO, assert wr_en (0x3C) and rd_n = 0 in the same cycle -> level = 1, rd_data unchanged. A following read returns 0x3C.
- Write 20 and read 20 interleaved so the pointers wrap past 15 -> data order preserved and level never exceeds 16. Then 5 writes, pulse clear -> level = 0, empty = 1, overflow = 0, rd_data unchanged.
- With UART_TX_FIFO_AFULL_EN defined: 11 writes -> almost_full = 0; the 12th write -> almost_full = 1; 1 read -> almost_full = 0. Assert aresetn low mid-burst -> all flags return to their reset values asynchronously.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo_if
//  Description : Bundle of the write/read handshake and status signals
//                between the APB register block / UART transmitter (master)
//                and the transmit byte FIFO (slave).
//                clear, wr_en, wr_data, rd_n           : master -> FIFO
//                rd_data, empty, full, level, overflow : FIFO -> master
//                almost_full                           : FIFO -> master, only
//                                                      with UART_TX_FIFO_AFULL_EN
//  Optional    : `define UART_TX_FIFO_AFULL_EN adds the almost_full signal.
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_tx_fifo_if #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
);
  logic                  clear;
  logic                  wr_en;
  logic [WIDTH-1:0]      wr_data;
  logic                  rd_n;
  logic [WIDTH-1:0]      rd_data;
  logic                  empty;
  logic                  full;
  logic [DEPTH_LOG2:0]   level;
  logic                  overflow;
`ifdef UART_TX_FIFO_AFULL_EN
  logic                  almost_full;

  modport master (
    output clear, wr_en, wr_data, rd_n,
    input  rd_data, empty, full, level, overflow, almost_full
  );
  modport slave (
    input  clear, wr_en, wr_data, rd_n,
    output rd_data, empty, full, level, overflow, almost_full
  );
`else
  modport master (
    output clear, wr_en, wr_data, rd_n,
    input  rd_data, empty, full, level, overflow
  );
  modport slave (
    input  clear, wr_en, wr_data, rd_n,
    output rd_data, empty, full, level, overflow
  );
`endif
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : Transmit-side byte FIFO in front of the UART transmitter.
//                The APB side writes bytes; the transmitter pops them with an
//                active-low strobe and takes the registered head byte one
//                clock later. Provides registered empty/full/level flags and
//                a sticky overflow flag for dropped writes.
//  Ports       : clk      - system clock
//                aresetn  - asynchronous active-low reset
//                bus      - uart_tx_fifo_if.slave (clear, wr_en, wr_data,
//                           rd_n in; rd_data, empty, full, level, overflow
//                           [, almost_full] out)
//  Optional    : `define UART_TX_FIFO_AFULL_EN adds the AFULL_THRESH
//                parameter and the registered almost_full output.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int WIDTH        = 8,
`ifdef UART_TX_FIFO_AFULL_EN
  parameter int AFULL_THRESH = 12,
`endif
  parameter int DEPTH_LOG2   = 4
) (
  input  logic             clk,
  input  logic             aresetn,
  uart_tx_fifo_if.slave    bus
);

  localparam int                  c_DEPTH_N   = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] c_DEPTH     = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] c_LVL_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]      mem_q [c_DEPTH_N];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  empty_q, full_q, overflow_q;
  logic [WIDTH-1:0]      rd_data_q;

  logic                  w_rd_acc;
  logic                  w_wr_acc;
  logic                  w_wr_drop;

  // A write into a full FIFO is still accepted when a read frees a slot on
  // the same edge; a read from an empty FIFO is never accepted (no
  // fall-through), so the same-cycle write just lands in storage.
  assign w_rd_acc  = !bus.rd_n && !empty_q;
  assign w_wr_acc  = bus.wr_en && (!full_q || w_rd_acc);
  assign w_wr_drop = bus.wr_en && !w_wr_acc;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (bus.clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (w_wr_acc) wr_ptr_d = wr_ptr_q + c_PTR_ONE;
      if (w_rd_acc) rd_ptr_d = rd_ptr_q + c_PTR_ONE;
      case ({w_wr_acc, w_rd_acc})
        2'b10:   level_d = level_q + c_LVL_ONE;
        2'b01:   level_d = level_q - c_LVL_ONE;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      empty_q  <= (level_d == '0);
      full_q   <= (level_d == c_DEPTH);
      if (bus.clear) begin
        overflow_q <= 1'b0;
      end else begin
        if (w_wr_drop) overflow_q <= 1'b1;
        // rd_data is held through clear and only moves on an accepted pop.
        if (w_rd_acc)  rd_data_q  <= mem_q[rd_ptr_q];
      end
    end
  end

  // Storage carries no reset: stale contents are unreachable once the
  // pointers and level are zeroed.
  always_ff @(posedge clk) begin
    if (w_wr_acc && !bus.clear) begin
      mem_q[wr_ptr_q] <= bus.wr_data;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.empty    = empty_q;
  assign bus.full     = full_q;
  assign bus.level    = level_q;
  assign bus.overflow = overflow_q;

`ifdef UART_TX_FIFO_AFULL_EN
  localparam logic [DEPTH_LOG2:0] c_AFULL = (DEPTH_LOG2+1)'(AFULL_THRESH);

  logic almost_full_q;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      almost_full_q <= 1'b0;
    end else begin
      // level_d is already zero under clear, but keep the clear explicit.
      almost_full_q <= !bus.clear && (level_d >= c_AFULL);
    end
  end

  assign bus.almost_full = almost_full_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_fifo
//  Description : Directed self-checking bench for uart_tx_fifo. Inputs are
//                driven 1 ns after the rising edge; outputs are sampled at
//                the same point, after the edge has settled.
//  Optional    : `define UART_TX_FIFO_AFULL_EN to also exercise almost_full.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx_fifo;

  localparam int c_WIDTH = 8;
  localparam int c_DL2   = 4;

  logic clk;
  logic aresetn;

  int n_checks;
  int n_errors;

  uart_tx_fifo_if #(.WIDTH(c_WIDTH), .DEPTH_LOG2(c_DL2)) bus ();

  uart_tx_fifo #(
    .WIDTH      (c_WIDTH),
`ifdef UART_TX_FIFO_AFULL_EN
    .AFULL_THRESH(12),
`endif
    .DEPTH_LOG2 (c_DL2)
  ) dut (
    .clk     (clk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock with the given strobes, then return inputs to idle.
  task automatic cyc(input logic wr, input logic [7:0] d, input logic rd, input logic clr);
    bus.wr_en   = wr;
    bus.wr_data = d;
    bus.rd_n    = ~rd;
    bus.clear   = clr;
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    bus.rd_n  = 1'b1;
    bus.clear = 1'b0;
  endtask

  task automatic wr(input logic [7:0] d);
    cyc(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic rd();
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    aresetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic [7:0] q[$];
  logic [7:0] exp_b;
  int         max_lvl;

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.rd_n    = 1'b1;
    bus.clear   = 1'b0;
    aresetn     = 1'b1;
    #1;
    do_reset();

    // Reset state
    check("rst_empty", bus.empty, 1);
    check("rst_full",  bus.full, 0);
    check("rst_level", bus.level, 0);
    check("rst_ovf",   bus.overflow, 0);
    check("rst_rdata", bus.rd_data, 8'h00);
`ifdef UART_TX_FIFO_AFULL_EN
    check("rst_afull", bus.almost_full, 0);
`endif

    // Single write then single read
    wr(8'hA5);
    check("w1_empty", bus.empty, 0);
    check("w1_level", bus.level, 1);
    rd();
    check("r1_empty", bus.empty, 1);
    check("r1_level", bus.level, 0);
    check("r1_rdata", bus.rd_data, 8'hA5);

    // Fill, overflow, drain
    for (int i = 0; i < 16; i++) wr(8'(i));
    check("fill_full",  bus.full, 1);
    check("fill_level", bus.level, 16);
    check("fill_ovf",   bus.overflow, 0);
    wr(8'hFF);
    check("ovf_flag",  bus.overflow, 1);
    check("ovf_level", bus.level, 16);
    for (int i = 0; i < 16; i++) begin
      rd();
      check("drain_data", bus.rd_data, 32'(i));
    end
    check("drain_empty", bus.empty, 1);
    check("ovf_sticky",  bus.overflow, 1);
    rd();
    check("rd_empty_hold", bus.rd_data, 8'h0F);
    check("rd_empty_lvl",  bus.level, 0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    check("clr_ovf",   bus.overflow, 0);
    check("clr_rdata", bus.rd_data, 8'h0F);

    // Simultaneous read and write while full
    for (int i = 0; i < 16; i++) wr(8'h10 + 8'(i));
    check("full2", bus.full, 1);
    cyc(1'b1, 8'h99, 1'b1, 1'b0);
    check("rw_full_level", bus.level, 16);
    check("rw_full_ovf",   bus.overflow, 0);
    check("rw_full_rdata", bus.rd_data, 8'h10);
    for (int i = 0; i < 16; i++) begin
      rd();
      exp_b = (i < 15) ? 8'h11 + 8'(i) : 8'h99;
      check("rw_full_drain", bus.rd_data, 32'(exp_b));
    end

    // Simultaneous read and write while empty: no fall-through
    cyc(1'b1, 8'h3C, 1'b1, 1'b0);
    check("rw_empty_level", bus.level, 1);
    check("rw_empty_rdata", bus.rd_data, 8'h99);
    rd();
    check("rw_empty_next", bus.rd_data, 8'h3C);
    check("rw_empty_emp",  bus.empty, 1);

    // Interleaved traffic across pointer wrap; stream of back-to-back ops
    max_lvl = 0;
    for (int i = 0; i < 20; i++) begin
      wr(8'h40 + 8'(i));
      q.push_back(8'h40 + 8'(i));
      if (i % 3 == 2) begin
        wr(8'hC0 + 8'(i));
        q.push_back(8'hC0 + 8'(i));
      end
      if (int'(bus.level) > max_lvl) max_lvl = int'(bus.level);
      rd();
      exp_b = q.pop_front();
      check("wrap_data", bus.rd_data, 32'(exp_b));
    end
    while (q.size() > 0) begin
      rd();
      exp_b = q.pop_front();
      check("wrap_tail", bus.rd_data, 32'(exp_b));
    end
    check("wrap_maxlvl_ok", 32'(max_lvl <= 16), 1);
    check("wrap_empty", bus.empty, 1);

    // Partial fill then clear with competing read and write
    for (int i = 0; i < 5; i++) wr(8'h70 + 8'(i));
    check("pre_clr_level", bus.level, 5);
    cyc(1'b1, 8'hEE, 1'b1, 1'b1);
    check("clr_level", bus.level, 0);
    check("clr_empty", bus.empty, 1);
    check("clr_full",  bus.full, 0);
    check("clr_ovf2",  bus.overflow, 0);
    check("clr_hold",  bus.rd_data, 32'(exp_b));
    wr(8'h5A);
    rd();
    check("post_clr_data", bus.rd_data, 8'h5A);

`ifdef UART_TX_FIFO_AFULL_EN
    for (int i = 0; i < 11; i++) wr(8'(i));
    check("af_11", bus.almost_full, 0);
    wr(8'h0B);
    check("af_12", bus.almost_full, 1);
    rd();
    check("af_rd", bus.almost_full, 0);
    wr(8'h0C);
    check("af_back", bus.almost_full, 1);
`endif

    // Asynchronous reset mid-burst: fill to full so every flag is non-reset
    bus.clear = 1'b0;
    while (!bus.full) wr(8'hAA);
    wr(8'hAB);
    check("pre_rst_ovf", bus.overflow, 1);
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'h11;
    #2;
    aresetn = 1'b0;
    #1;
    check("arst_level", bus.level, 0);
    check("arst_empty", bus.empty, 1);
    check("arst_full",  bus.full, 0);
    check("arst_ovf",   bus.overflow, 0);
    check("arst_rdata", bus.rd_data, 8'h00);
`ifdef UART_TX_FIFO_AFULL_EN
    check("arst_afull", bus.almost_full, 0);
`endif
    bus.wr_en = 1'b0;
    @(posedge clk);
    #1;
    aresetn = 1'b1;
    @(posedge clk);
    #1;
    wr(8'h66);
    rd();
    check("post_rst_data", bus.rd_data, 8'h66);
    check("post_rst_emp",  bus.empty, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
